// File: rtl/cam_pkg.sv
// +--------------------------------------------------------------------+
// | cam_pkg : shared state encoding and default geometry for capture    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package cam_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        SYNC    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } cam_state_t;

    localparam int c_H_PIXELS_DEF   = 160;
    localparam int c_V_LINES_DEF    = 120;
    localparam int c_FRAME_PIXELS   = c_H_PIXELS_DEF * c_V_LINES_DEF;

endpackage

`default_nettype wire

// File: rtl/cam_edge_det.sv
// +--------------------------------------------------------------------+
// | cam_edge_det : one-cycle delay register with rise/fall decode       |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module cam_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic r_dly;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dly <= 1'b0;
        end else begin
            r_dly <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_dly;
    assign o_fall = ~i_sig & r_dly;

endmodule

`default_nettype wire

// File: rtl/cam_capture_ctrl.sv
// +--------------------------------------------------------------------+
// | cam_capture_ctrl : Vsync-aligned OV7670 frame-capture sequencer     |
// | Optional: LINE_CHECK_EN adds per-line pixel check and o_line_err    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_PIXELS = c_H_PIXELS_DEF,
    parameter int V_LINES  = c_V_LINES_DEF,
    parameter int ADDR_W   = $clog2(c_FRAME_PIXELS)
) (
    input  logic              i_pclk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_continuous,
    input  logic              i_abort,
    input  logic              i_vsync,
    input  logic              i_href,
    output logic              o_wr_en,
    output logic              o_byte_phase,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_ovf,
    output logic [7:0]        o_line_cnt,
    output logic [7:0]        o_frame_cnt
`ifdef LINE_CHECK_EN
    ,
    output logic              o_line_err
`endif
);

    localparam logic [ADDR_W:0] c_FRM_CNT = (ADDR_W + 1)'(H_PIXELS * V_LINES);

    cam_state_t        r_state;
    cam_state_t        w_next;
    logic              w_vs_rise;
    logic              w_vs_fall;
    logic              w_hr_rise;
    logic              w_hr_fall;
    logic              w_full;
    logic              r_wr_en;
    logic              r_byte_phase;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_pix_cnt;
    logic              r_ovf;
    logic [7:0]        r_line_cnt;
    logic [7:0]        r_frame_cnt;
    logic              r_cont;

    cam_edge_det u_vs_edge (
        .i_clk  (i_pclk),
        .i_rst  (i_rst),
        .i_sig  (i_vsync),
        .o_rise (w_vs_rise),
        .o_fall (w_vs_fall)
    );

    cam_edge_det u_hr_edge (
        .i_clk  (i_pclk),
        .i_rst  (i_rst),
        .i_sig  (i_href),
        .o_rise (w_hr_rise),
        .o_fall (w_hr_fall)
    );

    assign w_full = (r_pix_cnt == c_FRM_CNT);

    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (i_abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (i_start)   w_next = ARM;
                ARM:     if (i_vsync)   w_next = SYNC;
                SYNC:    if (w_vs_fall) w_next = CAPTURE;
                CAPTURE: if (w_vs_rise) w_next = DONE;
                DONE:    w_next = r_cont ? SYNC : IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_en      <= 1'b0;
            r_byte_phase <= 1'b0;
            r_wr_addr    <= '0;
            r_pix_cnt    <= '0;
            r_ovf        <= 1'b0;
            r_line_cnt   <= '0;
            r_frame_cnt  <= '0;
            r_cont       <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_byte_phase <= 1'b0;
            // Address trails the strobe by one cycle and parks on the last slot once full
            if (r_wr_en && !w_full) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end
            if (!i_abort) begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_cont     <= i_continuous;
                            r_ovf      <= 1'b0;
                            r_line_cnt <= '0;
                        end
                    end
                    SYNC: begin
                        if (w_vs_fall) begin
                            r_wr_addr  <= '0;
                            r_pix_cnt  <= '0;
                            r_line_cnt <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (i_href) begin
                            r_byte_phase <= w_hr_rise | ~r_byte_phase;
                            if (r_byte_phase) begin
                                if (!w_full) begin
                                    r_wr_en   <= 1'b1;
                                    r_pix_cnt <= r_pix_cnt + 1'b1;
                                end else begin
                                    r_ovf <= 1'b1;
                                end
                            end
                        end
                        if (w_hr_fall && (r_line_cnt != 8'hFF)) begin
                            r_line_cnt <= r_line_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LINE_CHECK_EN
    localparam logic [15:0] c_LINE_PIX = 16'(H_PIXELS);

    logic [15:0] r_line_pix;
    logic        r_line_err;

    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            r_line_pix <= '0;
            r_line_err <= 1'b0;
        end else if (!i_abort) begin
            if ((r_state == IDLE) && i_start) begin
                r_line_err <= 1'b0;
            end else if ((r_state == SYNC) && w_vs_fall) begin
                r_line_pix <= '0;
            end else if (r_state == CAPTURE) begin
                if (w_hr_fall) begin
                    r_line_pix <= '0;
                    if (r_line_pix != c_LINE_PIX) begin
                        r_line_err <= 1'b1;
                    end
                end else if (i_href && r_byte_phase && (r_line_pix != 16'hFFFF)) begin
                    r_line_pix <= r_line_pix + 1'b1;
                end
            end
        end
    end

    assign o_line_err = r_line_err;
`endif

    assign o_wr_en      = r_wr_en;
    assign o_byte_phase = r_byte_phase;
    assign o_wr_addr    = r_wr_addr;
    assign o_busy       = (r_state != IDLE);
    assign o_frame_done = (r_state == DONE);
    assign o_ovf        = r_ovf;
    assign o_line_cnt   = r_line_cnt;
    assign o_frame_cnt  = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cam_capture_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_cam_capture_ctrl : randomized frame stimulus vs. reference model |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_cam_capture_ctrl;

    localparam int c_H  = 12;
    localparam int c_V  = 6;
    localparam int c_FP = c_H * c_V;
    localparam int c_AW = 15;

    logic            clk        = 1'b0;
    logic            rst        = 1'b1;
    logic            start      = 1'b0;
    logic            continuous = 1'b0;
    logic            abort_s    = 1'b0;
    logic            vsync      = 1'b1;
    logic            href       = 1'b0;
    logic            o_wr_en;
    logic            o_byte_phase;
    logic [c_AW-1:0] o_wr_addr;
    logic            o_busy;
    logic            o_frame_done;
    logic            o_ovf;
    logic [7:0]      o_line_cnt;
    logic [7:0]      o_frame_cnt;
`ifdef LINE_CHECK_EN
    logic            o_line_err;
`endif

    cam_capture_ctrl #(
        .H_PIXELS (c_H),
        .V_LINES  (c_V),
        .ADDR_W   (c_AW)
    ) dut (
        .i_pclk       (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_continuous (continuous),
        .i_abort      (abort_s),
        .i_vsync      (vsync),
        .i_href       (href),
        .o_wr_en      (o_wr_en),
        .o_byte_phase (o_byte_phase),
        .o_wr_addr    (o_wr_addr),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_ovf        (o_ovf),
        .o_line_cnt   (o_line_cnt),
        .o_frame_cnt  (o_frame_cnt)
`ifdef LINE_CHECK_EN
        ,
        .o_line_err   (o_line_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
    endtask

    // Reference model: what an ideal capture engine should have produced so far
    typedef struct { int cyc; int addr; } wexp_t;
    wexp_t wq[$];
    int    fq[$];
    bit    m_armed    = 0;
    bit    m_cont     = 0;
    bit    m_ovf      = 0;
    bit    m_line_err = 0;
    int    m_line_cnt = 0;
    int    m_frame_cnt = 0;
    int    m_last_addr = 0;

    logic  p_start = 1'b0;
    logic  p_abort = 1'b0;
    logic  p_cont  = 1'b0;

    always @(negedge clk) begin
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            check_eq("wr_en", o_wr_en, 1);
            check_eq("wr_addr", o_wr_addr, wq[0].addr);
            void'(wq.pop_front());
        end else begin
            check_eq("wr_en", o_wr_en, 0);
        end
        if (fq.size() > 0 && fq[0] == cyc) begin
            check_eq("frame_done", o_frame_done, 1);
            void'(fq.pop_front());
        end else begin
            check_eq("frame_done", o_frame_done, 0);
        end
    end

    task automatic step(input logic vs, input logic hr);
        @(negedge clk);
        vsync      = vs;
        href       = hr;
        start      = p_start;
        abort_s    = p_abort;
        continuous = p_cont;
        p_start    = 1'b0;
        p_abort    = 1'b0;
    endtask

    function automatic void model_start(input bit c);
        if (!m_armed) begin
            m_armed    = 1;
            m_cont     = c;
            m_ovf      = 0;
            m_line_cnt = 0;
            m_line_err = 0;
        end
    endfunction

    task automatic do_start(input bit c);
        p_start = 1'b1;
        p_cont  = c;
        model_start(c);
        step(1, 0);
        step(1, 0);
    endtask

    task automatic do_abort();
        p_abort = 1'b1;
        m_armed = 0;
        step(1, 0);
        step(1, 0);
    endtask

    task automatic drive_frame(input int n_lines, input int short_line, input int abort_pix,
                               input int mid_start_line, input bit stray);
        bit cap;
        bit sim_end;
        int npix;
        cap     = m_armed;
        sim_end = 1'($urandom_range(0, 1));
        npix    = 0;
        if (cap) m_line_cnt = 0;
        repeat (2 + $urandom_range(0, 2)) step(1, 0);
        step(0, 0);
        repeat ($urandom_range(0, 2)) step(0, 0);
        for (int l = 0; l < n_lines; l++) begin
            int len;
            int lp;
            bit odd;
            len = (l == short_line) ? c_H - 1 : c_H;
            lp  = 0;
            odd = ($urandom_range(0, 3) == 0);
            if (l == mid_start_line) begin
                p_start = 1'b1;
                p_cont  = 1'b0;
                model_start(0);
                step(0, 0);
            end
            for (int p = 0; p < len; p++) begin
                if (cap && npix == abort_pix) begin
                    p_abort     = 1'b1;
                    cap         = 0;
                    m_armed     = 0;
                    m_last_addr = npix;
                end
                if (stray && cap && l == 1 && p == 2) begin
                    p_start = 1'b1;
                    p_cont  = 1'($urandom);
                end
                step(0, 1);
                step(0, 1);
                if (cap) begin
                    if (npix < c_FP) wq.push_back('{cyc + 1, npix});
                    else m_ovf = 1;
                end
                npix++;
                lp++;
            end
            if (odd) step(0, 1);
            if (cap) begin
                m_line_cnt = (m_line_cnt >= 255) ? 255 : m_line_cnt + 1;
                if (lp != c_H) m_line_err = 1;
            end
            if (!(sim_end && l == n_lines - 1)) begin
                repeat (1 + $urandom_range(0, 2)) step(0, 0);
            end
        end
        step(1, 0);
        if (cap) begin
            fq.push_back(cyc + 1);
            m_frame_cnt++;
            m_last_addr = (npix >= c_FP) ? c_FP - 1 : npix;
            if (!m_cont) m_armed = 0;
        end
        repeat (3) step(1, 0);
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_busy"}, o_busy, m_armed);
        check_eq({tag, "_frame_cnt"}, o_frame_cnt, m_frame_cnt % 256);
        check_eq({tag, "_ovf"}, o_ovf, m_ovf);
        check_eq({tag, "_line_cnt"}, o_line_cnt, m_line_cnt);
        check_eq({tag, "_wr_addr"}, o_wr_addr, m_last_addr);
        check_eq({tag, "_byte_phase"}, o_byte_phase, 0);
`ifdef LINE_CHECK_EN
        check_eq({tag, "_line_err"}, o_line_err, m_line_err);
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_wr_en", o_wr_en, 0);
        check_eq("rst_byte_phase", o_byte_phase, 0);
        check_eq("rst_wr_addr", o_wr_addr, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_frame_done", o_frame_done, 0);
        check_eq("rst_ovf", o_ovf, 0);
        check_eq("rst_line_cnt", o_line_cnt, 0);
        check_eq("rst_frame_cnt", o_frame_cnt, 0);
`ifdef LINE_CHECK_EN
        check_eq("rst_line_err", o_line_err, 0);
`endif
        rst = 1'b0;
        repeat (2) step(1, 0);

        do_start(0);
        drive_frame(c_V, -1, -1, -1, 0);
        check_status("single");

        drive_frame(c_V, -1, -1, 2, 0);
        check_status("midstart_arm");
        drive_frame(c_V, -1, -1, -1, 0);
        check_status("midstart");

        do_start(1);
        for (int f = 0; f < 3; f++) begin
            drive_frame(c_V, -1, -1, -1, 1);
            check_status("cont");
        end
        do_abort();
        check_status("cont_abort");

        do_start(0);
        drive_frame(c_V + 1, -1, -1, -1, 0);
        check_status("ovf");
        do_start(0);
        check_eq("ovf_clear", o_ovf, m_ovf);
        drive_frame(c_V, -1, -1, -1, 0);
        check_status("after_ovf");

        do_start(0);
        drive_frame(c_V, -1, c_FP / 2 + 3, -1, 0);
        check_status("abort");

        do_start(0);
        drive_frame(c_V, 2, -1, -1, 0);
        check_status("short_line");

        for (int i = 0; i < 10; i++) begin
            if (!m_armed) do_start(1'($urandom_range(0, 1)));
            drive_frame(c_V + (($urandom_range(0, 3) == 0) ? 1 : 0),
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, c_V - 1)) : -1,
                        ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, c_FP - 1)) : -1,
                        -1,
                        1'($urandom_range(0, 1)));
            check_status("rand");
        end
        if (m_armed) do_abort();
        check_status("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Frame-capture sequencer for the OV7670 path. Arms on a software/button request, aligns to the camera frame boundary (Vsync), and generates the pixel-write strobe and frame-buffer address for the RGB565→RGB332 capture datapath. Supports single-shot and continuous capture and reports status. Sits between the camera pins and the frame-buffer write port, running entirely in the Pclk domain.

Parameters:
H_PIXELS, 160, pixels per line written to the buffer
V_LINES, 120, lines per frame written to the buffer
ADDR_W, 15, frame-buffer address width; H_PIXELS*V_LINES must be ≤ 2^ADDR_W

Ports:
Pclk  in  1  camera pixel clock, sole clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle capture request
continuous  in  1  1 = re-arm after each frame; 0 = single shot; sampled when start is accepted
abort  in  1  return to IDLE immediately
Vsync  in  1  camera vertical sync, high = blanking
Href  in  1  camera line valid
wr_en  out  1  one-cycle strobe per completed pixel (second byte)
byte_phase  out  1  0 = first byte of pixel, 1 = second byte
wr_addr  out  ADDR_W  buffer address for the current wr_en
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at end of each captured frame
ovf  out  1  sticky: pixels arrived beyond H_PIXELS*V_LINES
line_cnt  out  8  lines completed in current frame
frame_cnt  out  8  frames completed since reset, wraps 255→0

Behaviour:
- Reset (async, rst=1): state IDLE; every output 0; internal Vsync/Href delay registers 0.
- Vsync_d, Href_d: one-cycle registered copies for edge detection; rise/fall are decoded from current vs. delayed values.
- States: IDLE, ARM, SYNC, CAPTURE, DONE.
- IDLE: start=1 → ARM, latch continuous, clear ovf and line_cnt.
- ARM: wait for Vsync=1 (mid-frame starts are never captured) → SYNC.
- SYNC: on Vsync falling edge → CAPTURE; wr_addr=0, byte_phase=0, line_cnt=0.
- CAPTURE: while Href=1, byte_phase toggles each cycle. On a cycle with byte_phase=1, wr_en=1 (registered, visible the following cycle together with that pixel's wr_addr); wr_addr increments one cycle after the strobe. Href=0 forces byte_phase=0 (an odd trailing byte is discarded). Href falling edge → line_cnt+1, saturating at 255.
- Capacity: once H_PIXELS*V_LINES pixels have been written, further completed pixels produce no wr_en, wr_addr holds at the last address, and ovf is set.
- Vsync rising edge in CAPTURE → DONE.
- DONE (1 cycle): frame_done=1, frame_cnt+1. Next state: SYNC if continuous is latched, else IDLE.
- abort=1 in any state → IDLE next cycle; wr_en forced 0 that cycle; frame_done not pulsed. abort and start in the same cycle: abort wins.
- start outside IDLE is ignored.
- Simultaneous Href falling and Vsync rising: the line is counted, then the block enters DONE.
- Latency: first byte on the Pclk edge after Vsync falls → wr_en on the cycle after the second byte.

Optional Feature:
LINE_CHECK_EN: when defined, adds a per-line pixel counter and a sticky output line_err (1 bit). line_err is set if any line ends (Href falling) with a pixel count ≠ H_PIXELS, and is cleared when start is accepted. When not defined, the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cam_pkg: state encoding constants (IDLE=0 … DONE=4), default H_PIXELS/V_LINES, and a FRAME_PIXELS constant.
- One natural sub-module, cam_edge_det: registered rise/fall detector, instantiated for Vsync and Href.

Test Plan:
- Reset then single shot, 160×120 frame at 2 bytes/pixel → 19200 wr_en pulses, wr_addr 0..19199, one frame_done, busy then 0, frame_cnt=1.
- start asserted mid-frame (Vsync=0) → no wr_en until the next Vsync high→low; exactly one full frame captured.
- Continuous=1 over 3 frames → 3 frame_done pulses; wr_addr restarts at 0 each frame; frame_cnt=3; busy stays 1.
- Frame with 121 lines → wr_en stops after 19200 pixels, wr_addr holds at 19199, ovf=1 until the next accepted start.
- abort asserted at pixel 500 → IDLE next cycle, no further wr_en, no frame_done, busy=0.
- With LINE_CHECK_EN defined, one line of 159 pixels → line_err=1 after that line's Href falls; line_cnt still increments.
